// File: rtl/arm_mc_controller.sv
// Multicycle ARM control unit: fetch/decode/execute sequencing FSM, NZCV flag
// register, and condition evaluation that squashes failed instructions in DECODE.

module condcheck (
    input  logic [3:0] i_cond,
    input  logic [3:0] i_flags,
    output logic       o_condex
);
    logic w_n, w_z, w_c, w_v, w_ge;

    assign {w_n, w_z, w_c, w_v} = i_flags;
    assign w_ge = (w_n == w_v);

    always_comb begin
        o_condex = 1'b0;
        case (i_cond)
            4'b0000: o_condex = w_z;
            4'b0001: o_condex = ~w_z;
            4'b0010: o_condex = w_c;
            4'b0011: o_condex = ~w_c;
            4'b0100: o_condex = w_n;
            4'b0101: o_condex = ~w_n;
            4'b0110: o_condex = w_v;
            4'b0111: o_condex = ~w_v;
            4'b1000: o_condex = w_c & ~w_z;
            4'b1001: o_condex = ~(w_c & ~w_z);
            4'b1010: o_condex = w_ge;
            4'b1011: o_condex = ~w_ge;
            4'b1100: o_condex = ~w_z & w_ge;
            4'b1101: o_condex = ~(~w_z & w_ge);
            4'b1110: o_condex = 1'b1;
            default: o_condex = 1'bx;
        endcase
    end
endmodule

module arm_mc_controller #(
    parameter int NFLAGS = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [3:0]        Cond,
    input  logic [1:0]        Op,
    input  logic [5:0]        Funct,
    input  logic [3:0]        Rd,
    input  logic [NFLAGS-1:0] ALUFlags,
    output logic              PCWrite,
    output logic              RegWrite,
    output logic              MemWrite,
    output logic              IRWrite,
    output logic              AdrSrc,
    output logic [1:0]        ResultSrc,
    output logic              ALUSrcA,
    output logic [1:0]        ALUSrcB,
    output logic [1:0]        ALUControl,
    output logic [1:0]        ImmSrc,
    output logic [1:0]        RegSrc,
    output logic [NFLAGS-1:0] Flags,
    output logic [3:0]        State
);
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9
    } state_t;

    state_t            r_state, w_next;
    logic [NFLAGS-1:0] r_flags;
    logic              w_condex;
    logic [1:0]        w_aluctl, w_flagw;
    logic              w_pcwrite, w_regwrite, w_memwrite, w_irwrite;
    logic              w_rd_pc;

    condcheck u_condcheck (
        .i_cond   (Cond),
        .i_flags  (r_flags),
        .o_condex (w_condex)
    );

    assign w_rd_pc = (Rd == 4'd15);

    // ALU operation and flag-write mask from cmd; S=0 never writes flags.
    always_comb begin
        w_aluctl = 2'b00;
        w_flagw  = 2'b00;
        case (Funct[4:1])
            4'b0100: begin w_aluctl = 2'b00; w_flagw = 2'b11; end
            4'b0010: begin w_aluctl = 2'b01; w_flagw = 2'b11; end
            4'b0000: begin w_aluctl = 2'b10; w_flagw = 2'b10; end
            4'b1100: begin w_aluctl = 2'b11; w_flagw = 2'b10; end
            default: begin w_aluctl = 2'b00; w_flagw = 2'b00; end
        endcase
        if (!Funct[0]) w_flagw = 2'b00;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_FETCH;
        else          r_state <= w_next;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_flags <= '0;
        end else if (r_state == S_EXECR || r_state == S_EXECI) begin
            if (w_flagw[1]) r_flags[3:2] <= ALUFlags[3:2];
            if (w_flagw[0]) r_flags[1:0] <= ALUFlags[1:0];
        end
    end

    always_comb begin
        w_next     = S_FETCH;
        w_pcwrite  = 1'b0;
        w_regwrite = 1'b0;
        w_memwrite = 1'b0;
        w_irwrite  = 1'b0;
        AdrSrc     = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ALUControl = 2'b00;
        case (r_state)
            S_FETCH: begin
                w_irwrite = 1'b1;
                w_pcwrite = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                w_next    = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                // Cond=1111 is tested first so condcheck's X never steers the FSM.
                if (Cond == 4'b1111 || !w_condex) begin
                    w_next = S_FETCH;
                end else begin
                    case (Op)
                        2'b01:   w_next = S_MEMADR;
                        2'b00:   w_next = Funct[5] ? S_EXECI : S_EXECR;
                        2'b10:   w_next = S_BRANCH;
                        default: w_next = S_FETCH;
                    endcase
                end
            end
            S_MEMADR: begin
                ALUSrcB = 2'b01;
                w_next  = Funct[0] ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                AdrSrc = 1'b1;
                w_next = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc  = 2'b01;
                w_regwrite = 1'b1;
                w_pcwrite  = w_rd_pc;
                w_next     = S_FETCH;
            end
            S_MEMWR: begin
                AdrSrc     = 1'b1;
                w_memwrite = 1'b1;
                w_next     = S_FETCH;
            end
            S_EXECR: begin
                ALUSrcB    = 2'b00;
                ALUControl = w_aluctl;
                w_next     = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcB    = 2'b01;
                ALUControl = w_aluctl;
                w_next     = S_ALUWB;
            end
            S_ALUWB: begin
                w_regwrite = 1'b1;
                ResultSrc  = 2'b00;
                w_pcwrite  = w_rd_pc;
                w_next     = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                w_pcwrite = 1'b1;
                w_next    = S_FETCH;
            end
            default: w_next = S_FETCH;
        endcase
    end

    // Enables are gated by reset so FETCH cannot write while reset is held.
    assign PCWrite  = w_pcwrite  & reset_n;
    assign RegWrite = w_regwrite & reset_n;
    assign MemWrite = w_memwrite & reset_n;
    assign IRWrite  = w_irwrite  & reset_n;

    assign ImmSrc = Op;
    assign RegSrc = {Op == 2'b01, Op == 2'b10};
    assign Flags  = r_flags;
    assign State  = r_state;
endmodule

// File: tb/tb_arm_mc_controller.sv
// Bench for arm_mc_controller: directed instruction scenarios plus random
// instruction streams checked against an instruction-level reference model.

module tb_arm_mc_controller;
  logic       clk;
  logic       reset_n;
  logic [3:0] Cond;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic [3:0] ALUFlags;
  logic       PCWrite, RegWrite, MemWrite, IRWrite, AdrSrc, ALUSrcA;
  logic [1:0] ResultSrc, ALUSrcB, ALUControl, ImmSrc, RegSrc;
  logic [3:0] Flags;
  logic [3:0] State;

  int n_cmp = 0;
  int n_err = 0;

  logic [3:0]  m_flags;
  logic [19:0] exp_q[$];

  arm_mc_controller dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .Cond       (Cond),
    .Op         (Op),
    .Funct      (Funct),
    .Rd         (Rd),
    .ALUFlags   (ALUFlags),
    .PCWrite    (PCWrite),
    .RegWrite   (RegWrite),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .AdrSrc     (AdrSrc),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUControl (ALUControl),
    .ImmSrc     (ImmSrc),
    .RegSrc     (RegSrc),
    .Flags      (Flags),
    .State      (State)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] dut_ctl();
    return {PCWrite, RegWrite, MemWrite, IRWrite, AdrSrc, ResultSrc, ALUSrcA,
            ALUSrcB, ALUControl, ImmSrc, RegSrc};
  endfunction

  function automatic logic [15:0] ctl(input logic pc, input logic rw, input logic mw,
                                      input logic ir, input logic adr, input logic [1:0] res,
                                      input logic asa, input logic [1:0] asb,
                                      input logic [1:0] alu, input logic [1:0] op);
    return {pc, rw, mw, ir, adr, res, asa, asb, alu, op, op == 2'b01, op == 2'b10};
  endfunction

  // Condition test written from the mnemonic table: even codes hold, odd codes invert.
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v, base;
    {n, z, c, v} = f;
    case (cond[3:1])
      3'd0: base = z;
      3'd1: base = c;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = c && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    if (cond == 4'b1111) return 1'b0;
    if (cond == 4'b1110) return 1'b1;
    return cond[0] ? !base : base;
  endfunction

  // Returns {alu_op, write_nz, write_cv}.
  function automatic logic [3:0] alu_model(input logic [3:0] cmd, input logic s);
    logic [1:0] op;
    logic       nz, cv;
    op = 2'b00; nz = 1'b0; cv = 1'b0;
    if (cmd == 4'b0100)      begin op = 2'b00; nz = 1; cv = 1; end
    else if (cmd == 4'b0010) begin op = 2'b01; nz = 1; cv = 1; end
    else if (cmd == 4'b0000) begin op = 2'b10; nz = 1; end
    else if (cmd == 4'b1100) begin op = 2'b11; nz = 1; end
    return {op, nz & s, cv & s};
  endfunction

  // driver: executes one instruction from FETCH to the next FETCH, checking every cycle
  task automatic run_instr(input logic [3:0] cond, input logic [1:0] op,
                           input logic [5:0] funct, input logic [3:0] rd,
                           input logic [3:0] af);
    logic [3:0]  am;
    logic        rdpc;
    logic [19:0] e;
    Cond = cond; Op = op; Funct = funct; Rd = rd; ALUFlags = af;
    am   = alu_model(funct[4:1], funct[0]);
    rdpc = (rd == 4'd15);
    exp_q.push_back({4'd0, ctl(1, 0, 0, 1, 0, 2'b10, 1, 2'b10, 2'b00, op)});
    exp_q.push_back({4'd1, ctl(0, 0, 0, 0, 0, 2'b10, 1, 2'b10, 2'b00, op)});
    if (cond_pass(cond, m_flags)) begin
      if (op == 2'b01) begin
        exp_q.push_back({4'd2, ctl(0, 0, 0, 0, 0, 2'b00, 0, 2'b01, 2'b00, op)});
        if (funct[0]) begin
          exp_q.push_back({4'd3, ctl(0, 0, 0, 0, 1, 2'b00, 0, 2'b00, 2'b00, op)});
          exp_q.push_back({4'd4, ctl(rdpc, 1, 0, 0, 0, 2'b01, 0, 2'b00, 2'b00, op)});
        end else begin
          exp_q.push_back({4'd5, ctl(0, 0, 1, 0, 1, 2'b00, 0, 2'b00, 2'b00, op)});
        end
      end else if (op == 2'b00) begin
        if (funct[5]) exp_q.push_back({4'd7, ctl(0, 0, 0, 0, 0, 2'b00, 0, 2'b01, am[3:2], op)});
        else          exp_q.push_back({4'd6, ctl(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, am[3:2], op)});
        exp_q.push_back({4'd8, ctl(rdpc, 1, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, op)});
        if (am[1]) m_flags[3:2] = af[3:2];
        if (am[0]) m_flags[1:0] = af[1:0];
      end else if (op == 2'b10) begin
        exp_q.push_back({4'd9, ctl(1, 0, 0, 0, 0, 2'b10, 0, 2'b01, 2'b00, op)});
      end
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(negedge clk);
      check("state", {28'd0, State}, {28'd0, e[19:16]});
      check("ctrl", {16'd0, dut_ctl()}, {16'd0, e[15:0]});
      @(posedge clk);
    end
    #1;
    check("state_next_fetch", {28'd0, State}, 32'd0);
    check("flags", {28'd0, Flags}, {28'd0, m_flags});
  endtask

  logic [3:0] r_cmds[5];

  initial begin
    r_cmds[0] = 4'b0100; r_cmds[1] = 4'b0010; r_cmds[2] = 4'b0000;
    r_cmds[3] = 4'b1100; r_cmds[4] = 4'b0111;
    reset_n = 1'b0; Cond = 4'hE; Op = 2'b00; Funct = 6'd0; Rd = 4'd0; ALUFlags = 4'd0;
    m_flags = 4'd0;
    #1;
    check("rst_state", {28'd0, State}, 32'd0);
    check("rst_flags", {28'd0, Flags}, 32'd0);
    check("rst_enables", {28'd0, PCWrite, RegWrite, MemWrite, IRWrite}, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // directed scenarios
    run_instr(4'b1110, 2'b00, 6'b001000, 4'd3, 4'b1111);   // ADD reg, no S
    run_instr(4'b0000, 2'b01, 6'b011000, 4'd2, 4'b0000);   // STREQ with Z=0: squashed
    run_instr(4'b1110, 2'b01, 6'b011001, 4'd15, 4'b0000);  // LDR to PC
    run_instr(4'b1110, 2'b01, 6'b011000, 4'd4, 4'b0000);   // STR
    run_instr(4'b1110, 2'b00, 6'b000101, 4'd1, 4'b0100);   // SUBS -> Z
    run_instr(4'b0000, 2'b10, 6'b100000, 4'd0, 4'b0000);   // BEQ taken
    run_instr(4'b1110, 2'b00, 6'b000101, 4'd1, 4'b0011);   // SUBS -> CV
    run_instr(4'b1110, 2'b00, 6'b000001, 4'd1, 4'b1011);   // ANDS keeps CV
    run_instr(4'b1110, 2'b00, 6'b111001, 4'd15, 4'b0110);  // ORRS imm to PC
    run_instr(4'b1111, 2'b01, 6'b011000, 4'd4, 4'b0000);   // Cond=1111 squashed
    run_instr(4'b1111, 2'b00, 6'b001001, 4'd4, 4'b1111);   // Cond=1111 squashed
    run_instr(4'b1110, 2'b11, 6'b000000, 4'd0, 4'b0000);   // undefined op

    // async reset during MEMWR
    Cond = 4'b1110; Op = 2'b01; Funct = 6'b011000; Rd = 4'd5;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("pre_rst_state", {28'd0, State}, 32'd5);
    check("pre_rst_memwrite", {31'd0, MemWrite}, 32'd1);
    #1 reset_n = 1'b0;
    #1;
    m_flags = 4'd0;
    check("async_memwrite", {31'd0, MemWrite}, 32'd0);
    check("async_state", {28'd0, State}, 32'd0);
    check("async_flags", {28'd0, Flags}, 32'd0);
    @(negedge clk);
    check("held_enables", {28'd0, PCWrite, RegWrite, MemWrite, IRWrite}, 32'd0);
    check("held_state", {28'd0, State}, 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;

    // random instruction stream
    for (int i = 0; i < 300; i++) begin
      logic [3:0] cond, rd;
      logic [5:0] funct;
      cond  = ($urandom_range(0, 2) == 0) ? 4'b1110 : 4'($urandom_range(0, 15));
      funct = 6'($urandom);
      if ($urandom_range(0, 4) != 0) funct[4:1] = r_cmds[$urandom_range(0, 4)];
      rd    = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 14));
      run_instr(cond, 2'($urandom_range(0, 3)), funct, rd, 4'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
